da_mac_engine: RTL
==================

# da_mac_engine

Parametrised distributed-arithmetic (DA) multiply-accumulate engine for the DCT datapath. It is the successor to the fixed 4-input c4 coefficient ROM.
- Takes N_TAPS signed samples in one transfer and serialises them LSB-first.
- Each cycle, forms the DA address from one bit of every sample and looks up the partial coefficient sum combinationally from a run-time-loadable coefficient bank.
- Shift-accumulates the partial sums and presents the exact dot product on a ready/valid output.

## Interface
Parameters:
- N_TAPS, 4: number of samples/coefficients per dot product (power of two, 2..8).
- IN_W, 12: signed sample width.
- COEF_W, 17: signed coefficient width, Q(COEF_W-FRAC_W).FRAC_W.
- FRAC_W, 14: coefficient fraction bits; the result carries the same FRAC_W fraction bits.
- ACC_W, COEF_W+IN_W+$clog2(N_TAPS): result width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- cfg_we, in, 1: coefficient write strobe.
- cfg_idx, in, $clog2(N_TAPS): coefficient index.
- cfg_data, in, COEF_W: signed coefficient value.
- s_valid, in, 1: input samples valid.
- s_ready, out, 1: engine can accept samples.
- s_data, in, N_TAPS*IN_W: sample i is at s_data[i*IN_W +: IN_W], signed.
- m_valid, out, 1: result valid.
- m_ready, in, 1: downstream accepts result.
- m_data, out, ACC_W: signed dot product, sum over i of coef_i*x_i.
- busy, out, 1: high in RUN or DONE.

## Operation
- Coefficient bank: N_TAPS registers.
  - Reset value of every entry: C4_Q3_14 = 17'h02D41 (0.70710678 in Q3.14), zero/sign-extended to COEF_W.
  - A write is taken when cfg_we=1 and state==IDLE; the new value is used by the next accepted transfer.
  - cfg_we in RUN/DONE is dropped silently.
- FSM, three states:
  - IDLE: s_ready=1. On s_valid, capture samples into per-tap shift registers, clear acc, clear bit counter k, go to RUN.
  - RUN: one bit per cycle, k = 0..IN_W-1.
    - addr[i] = x_i[k].
    - P = sum of coef_i where addr[i]=1; signed, COEF_W+$clog2(N_TAPS) bits; addr=0 gives P=0.
    - For k<IN_W-1: acc += sign_ext(P) << k. For k=IN_W-1 (sign bit): acc -= sign_ext(P) << k.
    - After the k=IN_W-1 update, load m_data with acc and go to DONE.
  - DONE: m_valid=1, m_data held stable. When m_ready=1, go to IDLE.
  - No result and no input are accepted in the same cycle.
- Arithmetic is exact two's complement with no rounding or saturation. ACC_W is sized so the worst case (all x=-2^(IN_W-1), all coef=-2^(COEF_W-1)) does not overflow.
- Reset values: state IDLE, s_ready=1 once reset is released (s_ready=0 while rst_n=0), m_valid=0, m_data=0, busy=0, acc=0, k=0, coefficients=C4_Q3_14.
- Reset mid-operation aborts asynchronously. No partial result is emitted, and coefficients return to their defaults.

## Timing
- Transfer accepted at edge E (s_valid & s_ready). RUN occupies edges E+1..E+IN_W. m_valid is high from after edge E+IN_W; latency is IN_W cycles.
- m_valid stays high, and m_data is unchanged, until the edge where m_ready=1. s_ready rises in the following cycle.
- Maximum throughput is one result per IN_W+2 cycles with m_ready tied high.
- s_ready and busy are decoded from registered state only; no combinational path exists from any input to s_ready.
- The DA lookup is combinational within a cycle. The adder depth is $clog2(N_TAPS) levels plus the accumulator add.

## Structure
- Package da_pkg holds:
  - localparam C4_Q3_14 = 17'h02D41.
  - FSM state enum {IDLE, RUN, DONE}.
  - Helper widths: LUT_W = COEF_W+$clog2(N_TAPS).
- Sub-module da_coef_lut: purely combinational, inputs addr[N_TAPS-1:0] and the flattened coefficient vector, output signed LUT_W partial sum via an adder tree.
- Top-level da_mac_engine holds:
  - coefficient registers
  - sample shift registers
  - bit counter
  - accumulator
  - FSM and handshake

## Test plan
- Reset defaults, x={1,1,1,1} -> m_data=46340 (4*11585), m_valid rises IN_W=12 cycles after acceptance.
- Sign bit: x0=12'hFFF (-1), x1..x3=0 -> m_data=-11585.
- Extreme widths: all x=-2048, all coef=17'h10000 (-65536) -> m_data=536870912, no overflow.
- Config: in IDLE write coef[2]=17'h04000 (1.0), x2=3, others 0 -> m_data=49152 (3.0 in Q14). A cfg_we during RUN writing coef[2]=0 leaves that result unchanged.
- Backpressure: m_ready low for 5 cycles in DONE -> m_data stable, s_ready=0, a concurrent s_valid is not accepted until DONE exits.
- rst_n pulsed low during RUN at k=5 -> m_valid never asserts for that transfer, busy=0, and after release s_ready=1 and coefficients read back as defaults (next result with x={1,1,1,1} is 46340).

Source files
------------

// File: rtl/da_pkg.sv
// Shared constants, FSM encoding and width helpers for the distributed-arithmetic MAC engine.
package da_pkg;

    localparam logic [16:0] C4_Q3_14 = 17'h02D41;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one DA partial sum: a coefficient plus one carry bit per adder-tree level.
    function automatic int lut_w(input int coef_w, input int n_taps);
        return coef_w + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/da_coef_lut.sv
// Combinational DA lookup: sums the coefficients selected by one bit-slice of the samples.
module da_coef_lut
    import da_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int COEF_W = 17,
    parameter int LUT_W  = lut_w(COEF_W, N_TAPS)
) (
    input  logic [N_TAPS-1:0]        addr,
    input  logic [N_TAPS*COEF_W-1:0] coef,
    output logic signed [LUT_W-1:0]  psum
);

    // Heap-ordered binary tree: node 1 is the root, leaves live at N_TAPS..2*N_TAPS-1.
    logic signed [LUT_W-1:0] node [1:2*N_TAPS-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_TAPS; gi++) begin : g_leaf
            logic [COEF_W-1:0] c;
            assign c = coef[gi*COEF_W +: COEF_W];
            assign node[N_TAPS+gi] = addr[gi] ? {{(LUT_W-COEF_W){c[COEF_W-1]}}, c} : '0;
        end
        for (gi = 1; gi < N_TAPS; gi++) begin : g_sum
            assign node[gi] = node[2*gi] + node[2*gi+1];
        end
    endgenerate

    assign psum = node[1];

endmodule

// File: rtl/da_mac_engine.sv
// Bit-serial DA dot-product engine: one sample bit-slice per cycle, exact two's complement result.
module da_mac_engine
    import da_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int IN_W   = 12,
    parameter int COEF_W = 17,
    parameter int FRAC_W = 14,
    parameter int ACC_W  = COEF_W + IN_W + $clog2(N_TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(N_TAPS)-1:0] cfg_idx,
    input  logic [COEF_W-1:0]         cfg_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [N_TAPS*IN_W-1:0]    s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ACC_W-1:0]          m_data,
    output logic                      busy
);

    localparam int LUT_W = lut_w(COEF_W, N_TAPS);
    localparam int K_W   = $clog2(IN_W);
    localparam logic [COEF_W-1:0] COEF_RST = COEF_W'(C4_Q3_14);

    generate
        if (N_TAPS < 2 || FRAC_W >= COEF_W || ACC_W <= LUT_W) begin : g_param_check
            $error("da_mac_engine: unsupported parameter combination");
        end
    endgenerate

    state_t                  state_reg;
    logic                    ready_en_reg;
    logic [COEF_W-1:0]       coef_reg [N_TAPS];
    logic [IN_W-1:0]         x_reg [N_TAPS];
    logic [K_W-1:0]          k_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] psum_sh;
    logic signed [LUT_W-1:0] psum;
    logic [N_TAPS*COEF_W-1:0] coef_flat;
    logic [N_TAPS-1:0]       addr;
    logic                    last_bit;

    genvar gi;
    generate
        for (gi = 0; gi < N_TAPS; gi++) begin : g_tap
            assign coef_flat[gi*COEF_W +: COEF_W] = coef_reg[gi];
            assign addr[gi] = x_reg[gi][0];
        end
    endgenerate

    da_coef_lut #(
        .N_TAPS (N_TAPS),
        .COEF_W (COEF_W),
        .LUT_W  (LUT_W)
    ) u_lut (
        .addr (addr),
        .coef (coef_flat),
        .psum (psum)
    );

    // The sign-bit slice carries weight -2^(IN_W-1), hence the subtract on the last step.
    assign last_bit = (k_reg == K_W'(IN_W - 1));
    assign psum_sh  = {{(ACC_W-LUT_W){psum[LUT_W-1]}}, psum} <<< k_reg;
    assign acc_next = last_bit ? (acc_reg - psum_sh) : (acc_reg + psum_sh);

    // ready_en_reg keeps s_ready low through reset without a path from rst_n to the output.
    assign s_ready = ready_en_reg && (state_reg == IDLE);
    assign m_valid = (state_reg == DONE);
    assign busy    = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ready_en_reg <= 1'b0;
            acc_reg      <= '0;
            k_reg        <= '0;
            m_data       <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                coef_reg[i] <= COEF_RST;
                x_reg[i]    <= '0;
            end
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (cfg_we) begin
                        coef_reg[cfg_idx] <= cfg_data;
                    end
                    if (s_valid && s_ready) begin
                        for (int i = 0; i < N_TAPS; i++) begin
                            x_reg[i] <= s_data[i*IN_W +: IN_W];
                        end
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N_TAPS; i++) begin
                        x_reg[i] <= x_reg[i] >> 1;
                    end
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + K_W'(1);
                    if (last_bit) begin
                        m_data    <= acc_next;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
